// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: fetch FSM state encodings and default memory timeout.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_EXEC  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam int DEFAULT_MEM_TIMEOUT = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags the last permitted wait cycle.
module mem_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clock,
  input  logic clear,
  input  logic en,
  input  logic rst_cnt,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)        cnt <= '0;
    else if (rst_cnt) cnt <= '0;
    else if (en)      cnt <= cnt + W'(1);
  end

  assign expired = (cnt == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: PC -> MAR, memory -> MDR, MDR -> IR, then hand off
// to execute control until exec_done.
//
// state   | meaning
// S_IDLE  | waiting for run & !halt
// S_T0    | PC on bus, MAR latches, PC increments
// S_T1    | memory read in progress, waiting on mem_ready
// S_T2    | MDR on bus, IR latches, fetch retired
// S_EXEC  | execute control owns the datapath
// S_FAULT | memory timed out; held until clear
module fetch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 halt,
  input  logic                 mem_ready,
  input  logic                 exec_done,
  output logic                 PCout,
  output logic                 Inc,
  output logic                 MARin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 fetch_done,
  output logic                 busy,
  output logic                 mem_fault,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_t state, nextState;
  logic   waitExpired;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) uTimer (
    .clock   (clock),
    .clear   (clear),
    .en      (state == S_T1),
    .rst_cnt ((state != S_T1) || mem_ready),
    .expired (waitExpired)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= S_IDLE;
      instr_count <= '0;
    end else begin
      state <= nextState;
      if (state == S_T2) instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (run && !halt) nextState = S_T0;
      S_T0:    nextState = S_T1;
      // a ready in the final allowed cycle still completes the fetch
      S_T1:    if (mem_ready) nextState = S_T2;
               else if (waitExpired) nextState = S_FAULT;
      S_T2:    nextState = S_EXEC;
      S_EXEC:  if (exec_done) nextState = (halt || !run) ? S_IDLE : S_T0;
      S_FAULT: nextState = S_FAULT;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    PCout      = 1'b0;
    Inc        = 1'b0;
    MARin      = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    fetch_done = 1'b0;
    busy       = (state != S_IDLE);
    mem_fault  = (state == S_FAULT);
    case (state)
      S_T0: begin
        PCout = 1'b1;
        Inc   = 1'b1;
        MARin = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout     = 1'b1;
        IRin       = 1'b1;
        fetch_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: directed fetch scenarios, memory
// timeout, back-to-back fetches, mid-fetch clear.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0, halt = 1'b0, mem_ready = 1'b0, exec_done = 1'b0;
  logic        PCout, Inc, MARin, Read, MDRin, MDRout, IRin;
  logic        fetch_done, busy, mem_fault;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] countAtDone;
    int          reads;
  } exp_t;
  exp_t expQ[$];

  logic [31:0] pcReg  = 32'd100;
  logic [31:0] marReg = 32'd0;
  int          readCycles = 0;

  fetch_sequencer #(.CNT_WIDTH(32), .MEM_TIMEOUT(16)) dut (
    .clock(clock), .clear(clear), .run(run), .halt(halt),
    .mem_ready(mem_ready), .exec_done(exec_done),
    .PCout(PCout), .Inc(Inc), .MARin(MARin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .fetch_done(fetch_done), .busy(busy),
    .mem_fault(mem_fault), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // datapath model: PC and MAR react to the strobes
  always @(posedge clock) begin
    if (MARin) marReg <= pcReg;
    if (Inc)   pcReg  <= pcReg + 32'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doClear();
    @(posedge clock); #1 clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
  endtask

  function automatic logic [6:0] strobes();
    return {PCout, Inc, MARin, Read, MDRin, MDRout, IRin};
  endfunction

  // monitor: count read cycles per fetch, score every fetch_done
  always @(negedge clock) begin
    if (!clear) begin
      chk("bus_conflict", {31'd0, PCout & MDRout}, 32'd0);
      if (PCout) readCycles = 0;
      if (Read)  readCycles++;
      if (fetch_done) begin
        if (expQ.size() == 0) begin
          chk("unexpected_fetch_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          chk("count_at_fetch_done", instr_count, e.countAtDone);
          chk("read_cycles", readCycles, e.reads);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    // reset state
    #2;
    chk("reset_strobes", strobes(), 0);
    chk("reset_busy", busy, 0);
    chk("reset_fault", mem_fault, 0);
    chk("reset_count", instr_count, 0);
    tick(); tick();
    clear = 1'b0;

    // 1: single fetch, mem_ready in first T1 cycle
    run = 1'b1;
    tick();
    chk("t1_T0_strobes", strobes(), 7'b1110000);
    chk("t1_T0_busy", busy, 1);
    run = 1'b0; mem_ready = 1'b1;
    expQ.push_back('{32'd0, 1});
    tick();
    chk("t1_T1_strobes", strobes(), 7'b0001100);
    chk("t1_pc", pcReg, 101);
    chk("t1_mar", marReg, 100);
    tick();
    chk("t1_T2_strobes", strobes(), 7'b0000011);
    chk("t1_fetch_done", fetch_done, 1);
    mem_ready = 1'b0;
    tick();
    chk("t1_EXEC_strobes", strobes(), 0);
    chk("t1_EXEC_done_low", fetch_done, 0);
    chk("t1_EXEC_busy", busy, 1);
    chk("t1_count", instr_count, 1);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("t1_idle", busy, 0);

    // 2: mem_ready delayed 5 cycles
    doClear();
    run = 1'b1;
    tick();
    run = 1'b0;
    expQ.push_back('{32'd0, 6});
    tick();
    repeat (5) begin
      chk("t2_wait_read", Read, 1);
      tick();
    end
    chk("t2_last_read", Read, 1);
    chk("t2_no_fault", mem_fault, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t2_fetch_done", fetch_done, 1);
    tick();
    chk("t2_count", instr_count, 1);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    chk("t2_idle", busy, 0);

    // 3: timeout after 16 T1 cycles, sticky fault
    doClear();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    for (int i = 1; i <= 16; i++) begin
      chk("t3_in_T1", {Read, mem_fault}, 2'b10);
      tick();
    end
    chk("t3_fault", mem_fault, 1);
    chk("t3_fault_strobes", strobes(), 0);
    chk("t3_fault_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      run = i[0]; exec_done = ~i[0]; mem_ready = i[0];
      tick();
      chk("t3_fault_sticky", {mem_fault, PCout}, 2'b10);
    end
    run = 1'b0; exec_done = 1'b0; mem_ready = 1'b0;
    clear = 1'b1;
    #1;
    chk("t3_clear_fault", mem_fault, 0);
    chk("t3_clear_busy", busy, 0);
    tick();
    clear = 1'b0;

    // 3b: mem_ready in the 16th T1 cycle beats the timeout
    run = 1'b1;
    tick();
    run = 1'b0;
    expQ.push_back('{32'd0, 16});
    tick();
    repeat (15) tick();
    chk("t3b_still_T1", Read, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t3b_fetch_done", fetch_done, 1);
    chk("t3b_no_fault", mem_fault, 0);
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;

    // 4: three back-to-back fetches, halt during third T1
    doClear();
    run = 1'b1; mem_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t4_T0", PCout, 1);
      expQ.push_back('{32'(k), 1});
      tick();
      chk("t4_T1", Read, 1);
      if (k == 2) halt = 1'b1;
      tick();
      chk("t4_T2", fetch_done, 1);
      tick();
      chk("t4_exec1", {busy, strobes()}, 8'b10000000);
      tick();
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      if (k < 2) chk("t4_no_bubble", PCout, 1);
      else       chk("t4_halt_idle", busy, 0);
    end
    chk("t4_count", instr_count, 3);
    halt = 1'b0; mem_ready = 1'b0;

    // 5: clear mid-T1, then restart with run held
    tick();
    chk("t5_T0", PCout, 1);
    tick(); tick();
    chk("t5_in_T1", Read, 1);
    clear = 1'b1;
    #1;
    chk("t5_abort_strobes", strobes(), 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_count", instr_count, 0);
    tick();
    clear = 1'b0;
    tick();
    chk("t5_fresh_T0", PCout, 1);
    run = 1'b0; mem_ready = 1'b1;
    expQ.push_back('{32'd0, 1});
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;

    // 6: exec_done in IDLE has no effect
    chk("t6_idle", busy, 0);
    exec_done = 1'b1; tick(); tick(); exec_done = 1'b0;
    chk("t6_exec_done_ignored", {busy, strobes()}, 0);
    chk("t6_count", instr_count, 1);

    tick(); tick();
    chk("scoreboard_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
